// File: rtl/tinymips_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tinymips_clk_pkg
// Brief    : Shared types and phase encoding for the four-phase clock
//            generator and its run/step controller.
// Revision : 1.0 - initial release
// ============================================================================
package tinymips_clk_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Generator phase code {phase0, phase1}; HOME is the only stop point
  localparam logic [1:0] PH_HOME = 2'b00;
  localparam logic [1:0] PH_A    = 2'b10;
  localparam logic [1:0] PH_B    = 2'b11;
  localparam logic [1:0] PH_C    = 2'b01;

  // Phase the generator moves to on an unpaused edge
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_HOME: nxt = PH_A;
      PH_A:    nxt = PH_B;
      PH_B:    nxt = PH_C;
      default: nxt = PH_HOME;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : phase_seq_checker
// Brief    : Watches the generator phase outputs against the pause it was
//            given and raises a sticky error on any illegal pattern:
//            broken complements, movement while paused, or out-of-order
//            advance while running.
// Revision : 1.0 - initial release
// ============================================================================
module phase_seq_checker
  import tinymips_clk_pkg::*;
(
  input  logic clk_in,
  input  logic rst,
  input  logic phase0,
  input  logic phase1,
  input  logic phase2,
  input  logic phase3,
  input  logic pause,
  output logic phase_error
);

  logic [1:0] w_ph;
  logic       w_compl_bad;
  logic       w_seq_bad;
  logic [1:0] r_prev_ph;
  logic       r_prev_pause;
  logic       r_error;

  assign w_ph        = {phase0, phase1};
  assign w_compl_bad = (phase2 != ~phase0) | (phase3 != ~phase1);
  // The phase seen now was produced by the generator using last edge's pause
  assign w_seq_bad   = r_prev_pause ? (w_ph != r_prev_ph)
                                    : (w_ph != next_phase(r_prev_ph));

  // History of phase and pause, plus the sticky error flag
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_prev_ph    <= PH_HOME;
      r_prev_pause <= 1'b1;
      r_error      <= 1'b0;
    end else begin
      r_prev_ph    <= w_ph;
      r_prev_pause <= pause;
      if (w_compl_bad || w_seq_bad) begin
        r_error <= 1'b1;
      end
    end
  end

  assign phase_error = r_error;

endmodule
`default_nettype wire

// File: rtl/phase_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : phase_step_controller
// Brief    : Run / single-step / multi-step controller for the four-phase
//            clock generator. Stops the generator only at the home phase,
//            counts completed instruction cycles and flags phase errors.
//            Optional breakpoint input enabled by PHASE_STEP_BREAKPOINT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module phase_step_controller
  import tinymips_clk_pkg::*;
#(
  parameter int CYCLE_CNT_W = 32,
  parameter int STEP_N_W    = 8
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   phase0,
  input  logic                   phase1,
  input  logic                   phase2,
  input  logic                   phase3,
  input  logic                   run_req,
  input  logic                   step_req,
  input  logic [STEP_N_W-1:0]    step_n,
  input  logic                   halt_req,
`ifdef PHASE_STEP_BREAKPOINT_EN
  input  logic                   bp_hit,
  output logic                   bp_stop,
`endif
  output logic                   pause,
  output logic                   busy,
  output logic                   cycle_done,
  output logic [CYCLE_CNT_W-1:0] cycle_count,
  output logic                   phase_error
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_pause;
  logic [STEP_N_W-1:0]    r_remaining;
  logic [STEP_N_W-1:0]    w_remaining_nxt;
  logic                   r_cycle_done;
  logic [CYCLE_CNT_W-1:0] r_cycle_count;
  logic                   w_boundary;
  logic                   w_halt;
  logic                   w_bp_halt;

  // The generator wraps 01 -> 00 on this edge, completing one cycle
  assign w_boundary = ~r_pause & ({phase0, phase1} == PH_C);

`ifdef PHASE_STEP_BREAKPOINT_EN
  assign w_bp_halt = bp_hit & ((r_state == RUN) | (r_state == STEP));
`else
  assign w_bp_halt = 1'b0;
`endif
  assign w_halt = halt_req | w_bp_halt;

  // Next-state and step-count decode; halt beats run beats step
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    case (r_state)
      IDLE: begin
        if (halt_req) begin
          w_state_nxt = IDLE;
        end else if (run_req) begin
          w_state_nxt = RUN;
        end else if (step_req) begin
          w_state_nxt     = STEP;
          w_remaining_nxt = (step_n == '0) ? STEP_N_W'(1) : step_n;
        end
      end
      RUN: begin
        if (w_halt) begin
          w_state_nxt = w_boundary ? IDLE : DRAIN;
        end
      end
      STEP: begin
        if (w_halt) begin
          w_state_nxt = w_boundary ? IDLE : DRAIN;
        end else if (run_req) begin
          w_state_nxt     = RUN;
          w_remaining_nxt = '0;
        end else if (w_boundary) begin
          if (r_remaining <= STEP_N_W'(1)) begin
            w_state_nxt = IDLE;
          end else begin
            w_remaining_nxt = r_remaining - STEP_N_W'(1);
          end
        end
      end
      DRAIN: begin
        if (w_boundary) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == IDLE) begin
      w_remaining_nxt = '0;
    end
  end

  // State register; pause is re-registered so the generator sees a clean flop
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pause     <= 1'b1;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pause     <= (w_state_nxt == IDLE);
      r_remaining <= w_remaining_nxt;
    end
  end

  // Completed-cycle counter and one-clock completion strobe
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cycle_count <= '0;
      r_cycle_done  <= 1'b0;
    end else begin
      r_cycle_done <= w_boundary;
      if (w_boundary) begin
        r_cycle_count <= r_cycle_count + CYCLE_CNT_W'(1);
      end
    end
  end

`ifdef PHASE_STEP_BREAKPOINT_EN
  logic r_bp_cause;
  logic r_bp_stop;

  // Remember a breakpoint-initiated halt and report it once stopped
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_bp_cause <= 1'b0;
      r_bp_stop  <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_bp_cause <= 1'b0;
        if (run_req || step_req) begin
          r_bp_stop <= 1'b0;
        end
      end else if (w_state_nxt == IDLE) begin
        r_bp_stop  <= r_bp_cause | w_bp_halt;
        r_bp_cause <= 1'b0;
      end else if (w_bp_halt) begin
        r_bp_cause <= 1'b1;
      end
    end
  end

  assign bp_stop = r_bp_stop;
`endif

  phase_seq_checker u_checker (
    .clk_in      (clk_in),
    .rst         (rst),
    .phase0      (phase0),
    .phase1      (phase1),
    .phase2      (phase2),
    .phase3      (phase3),
    .pause       (r_pause),
    .phase_error (phase_error)
  );

  assign pause       = r_pause;
  assign busy        = (r_state != IDLE);
  assign cycle_done  = r_cycle_done;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_phase_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_step_controller
// Brief    : Directed bench for phase_step_controller with a behavioural
//            four-phase generator model driven by the controller's pause.
//            Build with PHASE_STEP_BREAKPOINT_EN to include breakpoint cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_step_controller;

  localparam int CNT_W  = 4;
  localparam int STEP_W = 8;

  logic              clk_in = 1'b0;
  logic              rst    = 1'b0;
  logic              run_req, step_req, halt_req;
  logic [STEP_W-1:0] step_n;
  logic              fault;
  logic              phase0, phase1, phase2, phase3;
  logic              pause, busy, cycle_done, phase_error;
  logic [CNT_W-1:0]  cycle_count;
`ifdef PHASE_STEP_BREAKPOINT_EN
  logic              bp_hit;
  logic              bp_stop;
`endif

  // Generator model state and bookkeeping
  logic [1:0] g_ph;
  int         n_adv = 0;
  int         n_bnd = 0;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk_in = ~clk_in;

  // Four-phase generator: advances on every edge where pause is low
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      g_ph  <= 2'b00;
      n_bnd <= 0;
    end else if (!pause) begin
      case (g_ph)
        2'b00:   g_ph <= 2'b10;
        2'b10:   g_ph <= 2'b11;
        2'b11:   g_ph <= 2'b01;
        default: g_ph <= 2'b00;
      endcase
      n_adv <= n_adv + 1;
      if (g_ph == 2'b01) n_bnd <= n_bnd + 1;
    end
  end

  assign phase0 = g_ph[1];
  assign phase1 = g_ph[0];
  assign phase2 = ~g_ph[1];
  assign phase3 = fault ? g_ph[0] : ~g_ph[0];

  phase_step_controller #(
    .CYCLE_CNT_W (CNT_W),
    .STEP_N_W    (STEP_W)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .phase0      (phase0),
    .phase1      (phase1),
    .phase2      (phase2),
    .phase3      (phase3),
    .run_req     (run_req),
    .step_req    (step_req),
    .step_n      (step_n),
    .halt_req    (halt_req),
`ifdef PHASE_STEP_BREAKPOINT_EN
    .bp_hit      (bp_hit),
    .bp_stop     (bp_stop),
`endif
    .pause       (pause),
    .busy        (busy),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count),
    .phase_error (phase_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One-clock request pulse; returns 1 unit after the sampling edge
  task automatic req(input logic r, input logic s, input logic h, input logic [STEP_W-1:0] n);
    @(negedge clk_in);
    run_req  = r;
    step_req = s;
    halt_req = h;
    step_n   = n;
    @(posedge clk_in);
    #1;
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic wait_ph(input logic [1:0] p, input string tag);
    for (int i = 0; i < 20 && {phase0, phase1} != p; i++) tick();
    check(tag, 32'({phase0, phase1}), 32'(p));
  endtask

  task automatic wait_idle(input string tag, output int pulses);
    pulses = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      tick();
      if (cycle_done) pulses++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, b0, p;
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; step_n = '0; fault = 1'b0;
`ifdef PHASE_STEP_BREAKPOINT_EN
    bp_hit = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_pause", 32'(pause), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(cycle_done), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    check("rst_perr", 32'(phase_error), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    tick();

    // Single step: pause low at edge k, four advances, stop at edge k+4
    a0 = n_adv;
    req(1'b0, 1'b1, 1'b0, 8'd1);
    check("s1_pause_k", 32'(pause), 32'd0);
    check("s1_busy_k", 32'(busy), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("s1_pause_mid", 32'(pause), 32'd0);
      check("s1_done_mid", 32'(cycle_done), 32'd0);
    end
    tick();
    check("s1_pause_end", 32'(pause), 32'd1);
    check("s1_done_end", 32'(cycle_done), 32'd1);
    check("s1_count", 32'(cycle_count), 32'd1);
    check("s1_busy_end", 32'(busy), 32'd0);
    check("s1_adv", 32'(n_adv - a0), 32'd4);
    check("s1_ph", 32'({phase0, phase1}), 32'd0);
    tick();
    check("s1_done_once", 32'(cycle_done), 32'd0);
    check("s1_ph_hold", 32'({phase0, phase1}), 32'd0);

    // step_n = 0 behaves as one cycle
    req(1'b0, 1'b1, 1'b0, 8'd0);
    wait_idle("s0_idle", p);
    check("s0_pulses", 32'(p), 32'd1);
    check("s0_count", 32'(cycle_count), 32'd2);

    // Three-cycle step
    a0 = n_adv;
    req(1'b0, 1'b1, 1'b0, 8'd3);
    wait_idle("s3_idle", p);
    check("s3_pulses", 32'(p), 32'd3);
    check("s3_adv", 32'(n_adv - a0), 32'd12);
    check("s3_count", 32'(cycle_count), 32'd5);
    check("s3_pause", 32'(pause), 32'd1);

    // Run, halt mid-cycle at ph=11: drain to the boundary
    req(1'b1, 1'b0, 1'b0, 8'd0);
    wait_ph(2'b11, "rh_wait11");
    b0 = n_bnd;
    req(1'b0, 1'b0, 1'b1, 8'd0);
    check("rh_drain_busy", 32'(busy), 32'd1);
    wait_idle("rh_idle", p);
    check("rh_pulses", 32'(p), 32'd1);
    check("rh_count", 32'(cycle_count), 32'((b0 + 1) % 16));
    check("rh_ph", 32'({phase0, phase1}), 32'd0);

    // Halt exactly on a boundary edge: straight to IDLE, no extra cycle
    req(1'b1, 1'b0, 1'b0, 8'd0);
    wait_ph(2'b01, "hb_wait01");
    b0 = n_bnd;
    req(1'b0, 1'b0, 1'b1, 8'd0);
    check("hb_busy", 32'(busy), 32'd0);
    check("hb_pause", 32'(pause), 32'd1);
    check("hb_done", 32'(cycle_done), 32'd1);
    check("hb_count", 32'(cycle_count), 32'((b0 + 1) % 16));
    repeat (4) tick();
    check("hb_no_extra", 32'(cycle_count), 32'((b0 + 1) % 16));
    check("hb_ph", 32'({phase0, phase1}), 32'd0);

    // run_req with halt_req from IDLE: halt wins
    req(1'b1, 1'b0, 1'b1, 8'd0);
    check("rh_same_busy", 32'(busy), 32'd0);
    check("rh_same_pause", 32'(pause), 32'd1);
    tick();
    check("rh_same_ph", 32'({phase0, phase1}), 32'd0);

    // step_req during RUN is ignored: keeps running past several boundaries
    req(1'b1, 1'b0, 1'b0, 8'd0);
    tick();
    req(1'b0, 1'b1, 1'b0, 8'd1);
    repeat (12) tick();
    check("rs_busy", 32'(busy), 32'd1);
    check("rs_pause", 32'(pause), 32'd0);
    req(1'b0, 1'b0, 1'b1, 8'd0);
    wait_idle("rs_idle", p);

    // Complement fault for one clock: sticky error
    check("pe_clean", 32'(phase_error), 32'd0);
    @(negedge clk_in);
    fault = 1'b1;
    @(posedge clk_in);
    #1;
    fault = 1'b0;
    check("pe_set", 32'(phase_error), 32'd1);
    repeat (5) tick();
    check("pe_sticky", 32'(phase_error), 32'd1);

    // Reset mid-cycle at ph=11
    req(1'b1, 1'b0, 1'b0, 8'd0);
    wait_ph(2'b11, "mr_wait11");
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    check("mr_pause", 32'(pause), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(cycle_done), 32'd0);
    check("mr_count", 32'(cycle_count), 32'd0);
    check("mr_perr", 32'(phase_error), 32'd0);
    check("mr_ph", 32'({phase0, phase1}), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    tick();

    // 17 cycles on a 4-bit counter wraps to 1
    a0 = n_adv;
    req(1'b0, 1'b1, 1'b0, 8'd17);
    wait_idle("wr_idle", p);
    check("wr_pulses", 32'(p), 32'd17);
    check("wr_adv", 32'(n_adv - a0), 32'd68);
    check("wr_count", 32'(cycle_count), 32'd1);
    check("wr_perr", 32'(phase_error), 32'd0);

`ifdef PHASE_STEP_BREAKPOINT_EN
    // Breakpoint during RUN stops at the next boundary and reports it
    check("bp_init", 32'(bp_stop), 32'd0);
    req(1'b1, 1'b0, 1'b0, 8'd0);
    tick();
    tick();
    @(negedge clk_in);
    bp_hit = 1'b1;
    @(posedge clk_in);
    #1;
    bp_hit = 1'b0;
    check("bp_busy", 32'(busy), 32'd1);
    wait_idle("bp_idle", p);
    check("bp_pulses", 32'(p), 32'd1);
    check("bp_stop", 32'(bp_stop), 32'd1);
    check("bp_ph", 32'({phase0, phase1}), 32'd0);
    req(1'b0, 1'b1, 1'b0, 8'd1);
    check("bp_clear", 32'(bp_stop), 32'd0);
    wait_idle("bp_step_idle", p);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phase_step_controller.md
Name: phase_step_controller

Overview:
Run/step controller that drives the `pause` input of the four-phase clock generator and consumes its phase outputs. It decodes the generator's phase state and lets the debug monitor run, single-step or multi-step the processor in whole instruction cycles. It stops the generator only at the home phase (phase0=0, phase1=0). It counts completed cycles and flags phase-sequence errors.

Parameters:
- CYCLE_CNT_W, 32: width of the completed-cycle counter.
- STEP_N_W, 8: width of the step-count request.

Ports:
- clk_in  input  1  clock; the same clock that feeds the generator.
- rst  input  1  reset, asynchronous, active-high.
- phase0..phase3  input  1 each  generator phase outputs.
- run_req  input  1  one-clock pulse: free-run.
- step_req  input  1  one-clock pulse: execute step_n cycles.
- step_n  input  STEP_N_W  cycle count, sampled with step_req; 0 is treated as 1.
- halt_req  input  1  one-clock pulse: stop at the next cycle boundary.
- pause  output  1  registered; to the generator's pause input.
- busy  output  1  high in any state except IDLE.
- cycle_done  output  1  one-clock pulse per completed cycle.
- cycle_count  output  CYCLE_CNT_W  number of completed cycles.
- phase_error  output  1  sticky error flag.

Behaviour:
- Reset (async, any time, including mid-cycle):
  - state=IDLE, pause=1, busy=0, cycle_done=0, cycle_count=0, phase_error=0, remaining=0.
  - The generator shares rst, so its phase returns to home at the same time.
- Phase decode:
  - ph = {phase0, phase1}.
  - Legal advance order: 00 -> 10 -> 11 -> 01 -> 00. Home is 00.
  - The boundary edge is a clk_in edge where the registered pause=0 and ph=01; the generator reaches 00 on that edge.
- States and transitions:
  - IDLE (pause=1):
    - run_req -> RUN, pause<=0.
    - step_req -> STEP, pause<=0, remaining<=max(step_n,1).
  - RUN (pause=0):
    - halt_req -> DRAIN.
    - step_req is ignored.
  - STEP (pause=0):
    - At each boundary edge remaining decrements. When remaining==1 at a boundary edge: pause<=1, -> IDLE.
    - run_req -> RUN and clears remaining.
    - halt_req -> DRAIN.
  - DRAIN (pause=0):
    - At the next boundary edge: pause<=1, -> IDLE.
    - run_req and step_req are ignored.
- Every boundary edge:
  - cycle_count<=cycle_count+1, wrapping modulo 2^CYCLE_CNT_W.
  - cycle_done<=1 for exactly one clock.
- Simultaneous requests: halt_req > run_req > step_req.
- halt_req arriving on a boundary edge goes directly to IDLE (pause<=1) and does not enter DRAIN.
- halt_req in IDLE is a no-op.
- Latency for a 1-cycle step with step_req sampled at edge k:
  - pause=0 from edge k.
  - Generator advances at k+1, k+2, k+3 and k+4.
  - pause=1 and cycle_done=1 after edge k+4.
  - ph=00 thereafter.
- phase_error is set at any edge where any of the following holds:
  - phase2 != ~phase0, or phase3 != ~phase1.
  - ph changed while the previous-edge pause=1.
  - ph did not follow the legal order while the previous-edge pause=0.
  - phase_error is cleared only by rst and does not affect the state machine.
- busy = (state != IDLE).

Optional Feature:
- Macro PHASE_STEP_BREAKPOINT_EN.
- Defined:
  - Adds input bp_hit (1 bit, level).
  - bp_hit=1 in RUN or STEP behaves as halt_req, ending at the next boundary.
  - Adds output bp_stop (1 bit), set when the stop was caused by bp_hit and cleared on the next run_req or step_req.
- Undefined: neither port exists and behaviour is as above.

Decomposition:
- Shared package `tinymips_clk_pkg`:
  - state enum (IDLE, RUN, STEP, DRAIN).
  - phase encoding constants PH_HOME=2'b00, PH_A=2'b10, PH_B=2'b11, PH_C=2'b01.
  - next-phase function.
- One sub-module, `phase_seq_checker`:
  - Inputs: phases and registered pause.
  - Output: sticky phase_error.
  - Keeps the checker separately verifiable.

Test Plan:
- Reset, then step_req with step_n=1 at edge k: pause low for edges k+1..k+4, ph returns to 00, cycle_done pulses once, cycle_count=1, busy=0.
- step_req with step_n=3: 12 generator advances, 3 cycle_done pulses, cycle_count=3, then pause=1.
- run_req, then halt_req while ph=11: stops at ph=00 after that cycle completes. halt_req exactly on a boundary edge: IDLE with no extra cycle.
- run_req and halt_req in the same clock from IDLE: stays IDLE, pause=1. step_req during RUN is ignored.
- Force phase3=phase1 for one clock: phase_error=1 and remains 1 until rst. Assert rst mid-cycle (ph=11): all outputs return to reset values.
- CYCLE_CNT_W=4, run for 17 cycles: cycle_count wraps to 1. With PHASE_STEP_BREAKPOINT_EN, bp_hit during RUN: stop at the next boundary with bp_stop=1.
